// File: rtl/iterative_divider_64_32.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient
// bit per clock. Overflow (including divide-by-zero) is detected up front.
module iterative_divider_64_32 #(
    parameter int unsigned N = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [2*N-1:0]   A,
    input  logic [N-1:0]     B,
    output logic [N-1:0]     Q,
    output logic [N-1:0]     R,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    localparam int unsigned CW = ($clog2(N) > 0) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [N-1:0]  qsh_q, qsh_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [N-1:0]  rmd_q, rmd_d;
    logic          ovf_q, ovf_d;

    // The shifted-out MSB of rem must join the compare, hence N+1 bits.
    logic [N:0]    t;
    logic [N:0]    diff;

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        rem_d   = rem_q;
        qsh_d   = qsh_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        ovf_d   = ovf_q;
        t       = '0;
        diff    = '0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    b_d   = B;
                    rem_d = A[2*N-1:N];
                    qsh_d = A[N-1:0];
                    cnt_d = '0;
                    // A high half >= B means the quotient cannot fit (covers B == 0).
                    if (A[2*N-1:N] >= B) begin
                        state_d = DONE;
                        ovf_d   = 1'b1;
                        quo_d   = '1;
                        rmd_d   = '0;
                    end else begin
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                t    = {rem_q, qsh_q[N-1]};
                diff = t - {1'b0, b_q};
                if (t >= {1'b0, b_q}) begin
                    rem_d = diff[N-1:0];
                    qsh_d = {qsh_q[N-2:0], 1'b1};
                end else begin
                    rem_d = t[N-1:0];
                    qsh_d = {qsh_q[N-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N-1)) begin
                    state_d = DONE;
                    quo_d   = qsh_d;
                    rmd_d   = rem_d;
                    ovf_d   = 1'b0;
                end
            end

            DONE: begin
                if (!enable) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            b_q     <= '0;
            rem_q   <= '0;
            qsh_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            qsh_q   <= qsh_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Q    = quo_q;
    assign R    = rmd_q;
    assign ovf  = ovf_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_iterative_divider_64_32.sv
// Scoreboard bench for iterative_divider_64_32: directed vectors push expected
// {Q,R,ovf}; a monitor pops and compares on each rising edge of done.
module tb_iterative_divider_64_32;

    localparam int unsigned N = 32;

    logic           clk;
    logic           rst;
    logic           enable;
    logic [2*N-1:0] A;
    logic [N-1:0]   B;
    logic [N-1:0]   Q;
    logic [N-1:0]   R;
    logic           busy;
    logic           done;
    logic           ovf;

    int n_checks;
    int n_fail;

    logic [2*N:0] sb_q[$];
    logic         done_prev;

    iterative_divider_64_32 #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .A      (A),
        .B      (B),
        .Q      (Q),
        .R      (R),
        .busy   (busy),
        .done   (done),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pop one expectation per result presentation.
    initial done_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst && busy && done) begin
            check("busy_done_exclusive", {busy, done}, 2'b10);
        end
        if (!rst && done && !done_prev) begin
            if (sb_q.size() == 0) begin
                check("unexpected_result", 1'b1, 1'b0);
            end else begin
                logic [2*N:0] e;
                e = sb_q.pop_front();
                check("result_QRovf", {Q, R, ovf}, e);
            end
        end
        done_prev = done;
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset_outputs", {Q, R, busy, done, ovf}, '0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Start an operation, measure latency and busy time, optionally hold in DONE
    // or disturb operands mid-run, then drop enable for exactly one edge.
    task automatic run_op(input logic [2*N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] eq, input logic [N-1:0] er, input logic eo,
                          input int hold, input logic disturb);
        int lat;
        int bc;
        @(negedge clk);
        A = a;
        B = b;
        enable = 1'b1;
        sb_q.push_back({eq, er, eo});
        lat = 0;
        bc  = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) bc++;
            if (disturb && lat == 5) begin
                A = ~a;
                B = b ^ 32'h0000_00F3;
            end
        end while (!done && lat < 200);
        check("latency", lat, eo ? 1 : N + 1);
        check("busy_cycles", bc, eo ? 0 : N);
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
            check("hold_done_QR", {busy, done, Q, R}, {2'b01, eq, er});
        end
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("rearm_idle", {busy, done}, 2'b00);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        enable   = 1'b0;
        A        = '0;
        B        = '0;
        repeat (2) @(posedge clk);
        #1;
        check("initial_reset", {Q, R, busy, done, ovf}, '0);
        @(negedge clk);
        rst = 1'b0;

        run_op(64'd120, 32'd12, 32'd10, 32'd0, 1'b0, 0, 1'b0);

        for (int j = 0; j <= 10; j++) begin
            do_reset();
            run_op(64'(12 * j), 32'd12, 32'(j), 32'd0, 1'b0, 0, 1'b0);
        end

        run_op(64'd1000, 32'd7, 32'd142, 32'd6, 1'b0, 0, 1'b0);
        run_op(64'h0000_00FE_FFFF_FF01, 32'd255, 32'hFFFF_FFFF, 32'd0, 1'b0, 0, 1'b0);

        run_op(64'd5, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b1, 0, 1'b0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1, 0, 1'b0);
        run_op(64'h0000_0001_0000_0000, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 0, 1'b0);

        // Reset ten cycles into RUN: no result is expected from this start.
        @(negedge clk);
        A = 64'd5000;
        B = 32'd3;
        enable = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        check("midrun_busy", {busy, done}, 2'b10);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrun_reset", {Q, R, busy, done, ovf}, '0);
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b0;

        run_op(64'd108216, 32'd324, 32'd334, 32'd0, 1'b0, 0, 1'b0);
        run_op(64'd123456789, 32'd1000, 32'd123456, 32'd789, 1'b0, 0, 1'b1);
        run_op(64'd1000, 32'd7, 32'd142, 32'd6, 1'b0, 20, 1'b0);
        run_op(64'd1000000007, 32'd10, 32'd100000000, 32'd7, 1'b0, 0, 1'b0);

        repeat (2) @(posedge clk);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
